// File: rtl/mips32r1_mem_pkg.sv
// rtl/mips32r1_mem_pkg.sv - shared widths, arbiter state encoding and command record
package mips32r1_mem_pkg;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_D = 2'd1,
    GNT_I = 2'd2
  } arb_state_e;

  // Registered downstream command; a write never carries read=1.
  typedef struct packed {
    logic              read;
    logic [BE_W-1:0]   write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mips32r1_arb_watchdog.sv
// rtl/mips32r1_arb_watchdog.sv - grant-phase timeout counter with clear/active/expire
module mips32r1_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic active,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cycleCnt;

  // First grant cycle sees 0, so expiry lands on the TIMEOUT_CYCLES-th waiting cycle.
  assign expire = active && (cycleCnt == CW'(TIMEOUT_CYCLES - 1));

  // Count waiting cycles while granted; cleared whenever the arbiter is idle.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cycleCnt <= '0;
    end else if (active && !expire) begin
      cycleCnt <= cycleCnt + 1'b1;
    end
  end

endmodule

// File: rtl/mips32r1_mem_arbiter.sv
// rtl/mips32r1_mem_arbiter.sv - fetch/data arbiter onto one memory port; optional MIPS32R1_ARB_TIMEOUT_EN watchdog
module mips32r1_mem_arbiter #(
  parameter int ADDR_W         = 30,
  parameter int DATA_W         = 32,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              InstMem_Read,
  input  logic [ADDR_W-1:0] InstMem_Address,
  output logic [DATA_W-1:0] InstMem_In,
  output logic              InstMem_Ack,
  input  logic              DataMem_Read,
  input  logic [3:0]        DataMem_Write,
  input  logic [ADDR_W-1:0] DataMem_Address,
  input  logic [DATA_W-1:0] DataMem_Out,
  output logic [DATA_W-1:0] DataMem_In,
  output logic              DataMem_Ack,
  output logic              Mem_Read,
  output logic [3:0]        Mem_Write,
  output logic [ADDR_W-1:0] Mem_Address,
  output logic [DATA_W-1:0] Mem_DataOut,
  input  logic [DATA_W-1:0] Mem_DataIn,
  input  logic              Mem_Ack,
  output logic              Bus_Error
);

  import mips32r1_mem_pkg::*;

  arb_state_e state;
  mem_cmd_t   cmd;
  logic [3:0] starveCnt;
  logic       dataPend;
  logic       fetchStarved;
  logic       timeoutHit;
  logic       done;

  assign dataPend     = DataMem_Read || (DataMem_Write != 4'b0000);
  assign fetchStarved = InstMem_Read && (starveCnt == 4'(STARVE_LIMIT));

`ifdef MIPS32R1_ARB_TIMEOUT_EN
  logic wdExpire;

  mips32r1_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .clear (state == IDLE),
    .active(state != IDLE),
    .expire(wdExpire)
  );

  // A real Mem_Ack in the expiry cycle wins over the timeout.
  assign timeoutHit = wdExpire && !Mem_Ack;
  assign Bus_Error  = timeoutHit && !reset;
`else
  assign timeoutHit = 1'b0;
  assign Bus_Error  = 1'b0;
`endif

  // Completion of the granted access; suppressed while reset is asserted so an abandoned access never acks.
  assign done = (state != IDLE) && (Mem_Ack || timeoutHit) && !reset;

  assign InstMem_Ack = done && (state == GNT_I);
  assign DataMem_Ack = done && (state == GNT_D);
  assign InstMem_In  = (InstMem_Ack && Mem_Ack) ? Mem_DataIn : '0;
  assign DataMem_In  = (DataMem_Ack && Mem_Ack) ? Mem_DataIn : '0;

  assign Mem_Read    = cmd.read;
  assign Mem_Write   = cmd.write;
  assign Mem_Address = cmd.addr;
  assign Mem_DataOut = cmd.wdata;

  // Arbitrate in IDLE, hold the registered command until completion, then drop back to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cmd       <= '0;
      starveCnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (dataPend && !fetchStarved) begin
            state     <= GNT_D;
            cmd.read  <= (DataMem_Write == 4'b0000);
            cmd.write <= DataMem_Write;
            cmd.addr  <= DataMem_Address;
            cmd.wdata <= DataMem_Out;
            starveCnt <= InstMem_Read ? starveCnt + 4'd1 : 4'd0;
          end else if (InstMem_Read) begin
            state     <= GNT_I;
            cmd.read  <= 1'b1;
            cmd.write <= 4'b0000;
            cmd.addr  <= InstMem_Address;
            cmd.wdata <= '0;
            starveCnt <= 4'd0;
          end else begin
            starveCnt <= 4'd0;
          end
        end
        default: begin
          if (Mem_Ack || timeoutHit) begin
            state <= IDLE;
            cmd   <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips32r1_mem_arbiter.sv
// tb/tb_mips32r1_mem_arbiter.sv - directed self-checking bench for mips32r1_mem_arbiter
module tb_mips32r1_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        InstMem_Read;
  logic [29:0] InstMem_Address;
  logic [31:0] InstMem_In;
  logic        InstMem_Ack;
  logic        DataMem_Read;
  logic [3:0]  DataMem_Write;
  logic [29:0] DataMem_Address;
  logic [31:0] DataMem_Out;
  logic [31:0] DataMem_In;
  logic        DataMem_Ack;
  logic        Mem_Read;
  logic [3:0]  Mem_Write;
  logic [29:0] Mem_Address;
  logic [31:0] Mem_DataOut;
  logic [31:0] Mem_DataIn;
  logic        Mem_Ack;
  logic        Bus_Error;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mips32r1_mem_arbiter #(
    .ADDR_W(30),
    .DATA_W(32),
    .STARVE_LIMIT(4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .InstMem_Read   (InstMem_Read),
    .InstMem_Address(InstMem_Address),
    .InstMem_In     (InstMem_In),
    .InstMem_Ack    (InstMem_Ack),
    .DataMem_Read   (DataMem_Read),
    .DataMem_Write  (DataMem_Write),
    .DataMem_Address(DataMem_Address),
    .DataMem_Out    (DataMem_Out),
    .DataMem_In     (DataMem_In),
    .DataMem_Ack    (DataMem_Ack),
    .Mem_Read       (Mem_Read),
    .Mem_Write      (Mem_Write),
    .Mem_Address    (Mem_Address),
    .Mem_DataOut    (Mem_DataOut),
    .Mem_DataIn     (Mem_DataIn),
    .Mem_Ack        (Mem_Ack),
    .Bus_Error      (Bus_Error)
  );

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    string      order;
    logic [7:0] kind;
    int         found;
    logic       sawErr;
    logic       sawAck;

    reset           = 1'b1;
    InstMem_Read    = 1'b0;
    InstMem_Address = '0;
    DataMem_Read    = 1'b0;
    DataMem_Write   = 4'b0000;
    DataMem_Address = '0;
    DataMem_Out     = '0;
    Mem_DataIn      = '0;
    Mem_Ack         = 1'b0;
    nxt();
    nxt();

    chk("rst_mem_read",  32'(Mem_Read),    32'd0);
    chk("rst_mem_write", 32'(Mem_Write),   32'd0);
    chk("rst_mem_addr",  32'(Mem_Address), 32'd0);
    chk("rst_mem_dout",  Mem_DataOut,      32'd0);
    chk("rst_iack",      32'(InstMem_Ack), 32'd0);
    chk("rst_dack",      32'(DataMem_Ack), 32'd0);
    chk("rst_buserr",    32'(Bus_Error),   32'd0);
    reset = 1'b0;

    // Single fetch, memory answers two cycles after the command.
    InstMem_Read    = 1'b1;
    InstMem_Address = 30'h10;
    #1;
    chk("f_no_cmd_yet", 32'(Mem_Read), 32'd0);
    nxt();
    chk("f_mem_read",  32'(Mem_Read),    32'd1);
    chk("f_mem_addr",  32'(Mem_Address), 32'h10);
    chk("f_mem_write", 32'(Mem_Write),   32'd0);
    chk("f_iack_wait", 32'(InstMem_Ack), 32'd0);
    nxt();
    chk("f_iack_wait2", 32'(InstMem_Ack), 32'd0);
    nxt();
    Mem_Ack    = 1'b1;
    Mem_DataIn = 32'h24080005;
    #1;
    chk("f_iack",     32'(InstMem_Ack), 32'd1);
    chk("f_idata",    InstMem_In,       32'h24080005);
    chk("f_dack_low", 32'(DataMem_Ack), 32'd0);
    nxt();
    Mem_Ack      = 1'b0;
    InstMem_Read = 1'b0;
    #1;
    chk("f_cmd_clear", 32'(Mem_Read),    32'd0);
    chk("f_iack_once", 32'(InstMem_Ack), 32'd0);

    // Simultaneous fetch and partial write: data first.
    nxt();
    InstMem_Read    = 1'b1;
    InstMem_Address = 30'h10;
    DataMem_Write   = 4'b0011;
    DataMem_Address = 30'h40;
    DataMem_Out     = 32'hDEADBEEF;
    nxt();
    chk("s_write_be",  32'(Mem_Write),   32'h3);
    chk("s_read_low",  32'(Mem_Read),    32'd0);
    chk("s_addr",      32'(Mem_Address), 32'h40);
    chk("s_wdata",     Mem_DataOut,      32'hDEADBEEF);
    Mem_Ack = 1'b1;
    #1;
    chk("s_dack",      32'(DataMem_Ack), 32'd1);
    chk("s_iack_low",  32'(InstMem_Ack), 32'd0);
    nxt();
    Mem_Ack       = 1'b0;
    DataMem_Write = 4'b0000;
    #1;
    chk("s_idle_gap",  32'(Mem_Write),   32'd0);
    nxt();
    chk("s_fetch_read", 32'(Mem_Read),    32'd1);
    chk("s_fetch_addr", 32'(Mem_Address), 32'h10);
    Mem_Ack    = 1'b1;
    Mem_DataIn = 32'h11112222;
    #1;
    chk("s_fetch_ack",  32'(InstMem_Ack), 32'd1);
    chk("s_fetch_data", InstMem_In,       32'h11112222);
    nxt();
    Mem_Ack         = 1'b0;
    InstMem_Read    = 1'b0;
    DataMem_Address = '0;
    DataMem_Out     = '0;

    // Starvation guard: fetch held against back-to-back data reads.
    nxt();
    order           = "DDDDIDD";
    InstMem_Read    = 1'b1;
    InstMem_Address = 30'h20;
    DataMem_Read    = 1'b1;
    DataMem_Address = 30'h80;
    for (int g = 0; g < 7; g++) begin
      nxt();
      if (Mem_Read && Mem_Address == 30'h80)      kind = "D";
      else if (Mem_Read && Mem_Address == 30'h20) kind = "I";
      else                                        kind = "?";
      chk($sformatf("st_grant%0d", g), 32'(kind), 32'(order[g]));
      Mem_Ack    = 1'b1;
      Mem_DataIn = 32'(g);
      #1;
      chk($sformatf("st_acks%0d", g), 32'({InstMem_Ack, DataMem_Ack}),
          (order[g] == "D") ? 32'b01 : 32'b10);
      nxt();
      Mem_Ack = 1'b0;
      if (g == 6) begin
        InstMem_Read = 1'b0;
        DataMem_Read = 1'b0;
      end
    end

    // Stray Mem_Ack while idle is ignored.
    Mem_Ack = 1'b1;
    #1;
    chk("idle_ack_ignored", 32'({InstMem_Ack, DataMem_Ack}), 32'd0);
    nxt();
    Mem_Ack = 1'b0;
    #1;
    chk("idle_no_cmd", 32'(Mem_Read), 32'd0);

    // Read and write both set: write wins.
    DataMem_Read    = 1'b1;
    DataMem_Write   = 4'b1111;
    DataMem_Address = 30'h55;
    DataMem_Out     = 32'hCAFEF00D;
    nxt();
    chk("rw_write", 32'(Mem_Write), 32'hF);
    chk("rw_read",  32'(Mem_Read),  32'd0);
    chk("rw_wdata", Mem_DataOut,    32'hCAFEF00D);

    // Reset in the middle of the granted write, then a late Mem_Ack.
    reset = 1'b1;
    nxt();
    chk("mr_write", 32'(Mem_Write),   32'd0);
    chk("mr_read",  32'(Mem_Read),    32'd0);
    chk("mr_addr",  32'(Mem_Address), 32'd0);
    chk("mr_dout",  Mem_DataOut,      32'd0);
    reset         = 1'b0;
    DataMem_Read  = 1'b0;
    DataMem_Write = 4'b0000;
    Mem_Ack       = 1'b1;
    #1;
    chk("mr_no_dack", 32'(DataMem_Ack), 32'd0);
    chk("mr_no_iack", 32'(InstMem_Ack), 32'd0);
    chk("mr_buserr",  32'(Bus_Error),   32'd0);
    nxt();
    Mem_Ack = 1'b0;
    nxt();

`ifdef MIPS32R1_ARB_TIMEOUT_EN
    // Memory never answers: watchdog completes the read with zero data.
    DataMem_Read    = 1'b1;
    DataMem_Address = 30'h99;
    found           = 0;
    for (int c = 1; c <= 20; c++) begin
      nxt();
      if (DataMem_Ack) begin
        found = c;
        chk("to_buserr", 32'(Bus_Error), 32'd1);
        chk("to_rdata",  DataMem_In,     32'd0);
        break;
      end
    end
    chk("to_cycle", 32'(found), 32'd8);
    nxt();
    DataMem_Read = 1'b0;
    #1;
    chk("to_cmd_drop",  32'(Mem_Read),  32'd0);
    chk("to_err_pulse", 32'(Bus_Error), 32'd0);
`else
    // Without the watchdog a slow memory is simply waited on.
    DataMem_Read    = 1'b1;
    DataMem_Address = 30'h99;
    sawErr          = 1'b0;
    sawAck          = 1'b0;
    for (int c = 0; c < 20; c++) begin
      nxt();
      sawErr = sawErr | Bus_Error;
      sawAck = sawAck | DataMem_Ack;
    end
    chk("wait_no_err", 32'(sawErr), 32'd0);
    chk("wait_no_ack", 32'(sawAck), 32'd0);
    chk("wait_holding", 32'(Mem_Read), 32'd1);
    Mem_Ack    = 1'b1;
    Mem_DataIn = 32'h00005A5A;
    #1;
    chk("wait_dack",  32'(DataMem_Ack), 32'd1);
    chk("wait_rdata", DataMem_In,       32'h00005A5A);
    nxt();
    Mem_Ack      = 1'b0;
    DataMem_Read = 1'b0;
`endif

    nxt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
